// File: rtl/prg_sched.sv
// prg_sched: round-robin scheduler that shares one fixed-latency PRG core
// between two requesters. One job is in flight at a time. The FSM walks
// IDLE -> RUN -> DONE -> IDLE, and the captured result is held until the
// consumer takes it.
module prg_sched #(
    parameter int CORE_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [39:0] req0_seed,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [39:0] req1_seed,
    output logic        req1_ready,
    output logic [39:0] core_seed,
    input  logic [23:0] core_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [23:0] res_data,
    output logic        res_id,
    output logic        busy,
    output logic [7:0]  job_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(CORE_LAT);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       last_grant;
    logic       grant;
    logic       idle_open;
    logic       accept;

    // Round-robin pick: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Ready is only offered from IDLE, and never while reset is held.
    assign idle_open  = (state == IDLE) && !rst;
    assign req0_ready = idle_open && req0_valid && !grant;
    assign req1_ready = idle_open && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    // Job sequencing: accept a seed, wait out the core latency, hold the result for the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            core_seed  <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
            job_cnt    <= '0;
            wait_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        core_seed  <= grant ? req1_seed : req0_seed;
                        res_id     <= grant;
                        last_grant <= grant;
                        wait_cnt   <= LAT;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // The counter reaching one marks the last RUN cycle, so
                    // RUN spans exactly CORE_LAT cycles.
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        res_data  <= core_out;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Nothing is accepted on the handshake edge itself.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        job_cnt   <= job_cnt + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prg_sched.sv
// tb_prg_sched: randomized and directed bench for prg_sched against a
// transaction-level timing model (accept interval, latency, handshake).
module tb_prg_sched;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        v0 = 1'b0, v1 = 1'b0, rr = 1'b0;
    logic [39:0] s0 = '0, s1 = '0;
    logic [23:0] cout = '0;
    logic        r0, r1, rv, rid, bz;
    logic [39:0] cseed;
    logic [23:0] rdata;
    logic [7:0]  jc;

    logic        b_v0 = 1'b0, b_v1 = 1'b0, b_rr = 1'b0;
    logic [39:0] b_s0 = '0, b_s1 = '0;
    logic [23:0] b_cout = '0;
    logic        b_r0, b_r1, b_rv, b_rid, b_bz;
    logic [39:0] b_cs;
    logic [23:0] b_rd;
    logic [7:0]  b_jc;

    int total = 0;
    int bad = 0;

    // Reference model state
    bit          act;
    int          acc;
    bit          last;
    int          cyc = 0;
    int          ncomp;
    bit          p_v0, p_v1, p_rr;
    logic [39:0] p_s0, p_s1;
    logic [23:0] p_cout;
    bit          exp_r0, exp_r1, exp_id;
    logic [39:0] exp_seed;
    logic [23:0] exp_data;
    logic [7:0]  exp_cnt;

    prg_sched #(.CORE_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_seed(s0), .req0_ready(r0),
        .req1_valid(v1), .req1_seed(s1), .req1_ready(r1),
        .core_seed(cseed), .core_out(cout),
        .res_valid(rv), .res_ready(rr), .res_data(rdata), .res_id(rid),
        .busy(bz), .job_cnt(jc)
    );

    prg_sched #(.CORE_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(b_v0), .req0_seed(b_s0), .req0_ready(b_r0),
        .req1_valid(b_v1), .req1_seed(b_s1), .req1_ready(b_r1),
        .core_seed(b_cs), .core_out(b_cout),
        .res_valid(b_rv), .res_ready(b_rr), .res_data(b_rd), .res_id(b_rid),
        .busy(b_bz), .job_cnt(b_jc)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    function automatic bit exp_busy();
        return act;
    endfunction

    function automatic bit exp_rv();
        return act && (cyc > acc + LAT);
    endfunction

    task automatic model_reset();
        act = 0; acc = 0; last = 1; ncomp = 0;
        exp_r0 = 0; exp_r1 = 0; exp_id = 0;
        exp_seed = '0; exp_data = '0; exp_cnt = '0;
        p_v0 = 0; p_v1 = 0; p_rr = 0; p_s0 = '0; p_s1 = '0; p_cout = '0;
    endtask

    // Drive idle inputs, hold reset, and release it on the next falling edge.
    task automatic apply_reset();
        v0 = 0; v1 = 0; rr = 0; s0 = '0; s1 = '0; cout = '0;
        rst = 1;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    // Advance one cycle: the model resolves the edge closing the previous
    // interval, then new inputs are applied and next-interval expectations formed.
    task automatic tick(input bit i_v0, input logic [39:0] i_s0, input bit i_v1,
                        input logic [39:0] i_s1, input logic [23:0] i_cout, input bit i_rr);
        if (!act) begin
            if ((exp_r0 && p_v0) || (exp_r1 && p_v1)) begin
                act = 1; acc = cyc; last = exp_r1; exp_id = exp_r1;
                exp_seed = exp_r1 ? p_s1 : p_s0;
            end
        end else if (cyc == acc + LAT) begin
            exp_data = p_cout;
        end else if (cyc > acc + LAT && p_rr) begin
            act = 0; exp_cnt = exp_cnt + 8'd1; ncomp++;
        end
        cyc++;
        @(posedge clk);
        #1;
        v0 = i_v0; s0 = i_s0; v1 = i_v1; s1 = i_s1; cout = i_cout; rr = i_rr;
        p_v0 = i_v0; p_s0 = i_s0; p_v1 = i_v1; p_s1 = i_s1; p_cout = i_cout; p_rr = i_rr;
        #1;
        exp_r0 = !act && i_v0 && (!i_v1 || last);
        exp_r1 = !act && i_v1 && (!i_v0 || !last);
    endtask

    task automatic test_reset();
        v0 = 1; v1 = 1; s0 = 40'h1111111111; s1 = 40'h2222222222; rr = 1;
        rst = 1;
        #1;
        total++; if (r0 !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%0b want=0", r0); end
        total++; if (r1 !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%0b want=0", r1); end
        total++; if (bz !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bz); end
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%0b want=0", rv); end
        total++; if (cseed !== 40'h0) begin bad++; $display("FAIL reset_core_seed got=%h want=0", cseed); end
        total++; if (rdata !== 24'h0) begin bad++; $display("FAIL reset_res_data got=%h want=0", rdata); end
        total++; if (rid !== 1'b0) begin bad++; $display("FAIL reset_res_id got=%0b want=0", rid); end
        total++; if (jc !== 8'h0) begin bad++; $display("FAIL reset_job_cnt got=%0d want=0", jc); end
        apply_reset();
    endtask

    task automatic test_single();
        int lat_seen;
        logic [23:0] prev_c, c;
        lat_seen = -1;
        prev_c = '0;
        tick(1, 40'h0102030405, 0, 40'h0, 24'h0, 1);
        total++; if (r0 !== 1'b1) begin bad++; $display("FAIL single_ready0 got=%0b want=1", r0); end
        total++; if (r1 !== 1'b0) begin bad++; $display("FAIL single_ready1 got=%0b want=0", r1); end
        for (int k = 1; k <= 8; k++) begin
            c = 24'($urandom);
            tick(0, 40'h0, 0, 40'h0, c, 1);
            if (k == 1) begin
                total++; if (cseed !== 40'h0102030405) begin bad++; $display("FAIL single_core_seed got=%h want=0102030405", cseed); end
                total++; if (bz !== 1'b1) begin bad++; $display("FAIL single_busy got=%0b want=1", bz); end
            end
            if (k == lat_seen + 1) begin
                total++; if (jc !== 8'd1) begin bad++; $display("FAIL single_job_cnt got=%0d want=1", jc); end
            end
            if (rv === 1'b1 && lat_seen < 0) begin
                lat_seen = k;
                total++; if (rdata !== prev_c) begin bad++; $display("FAIL single_res_data got=%h want=%h", rdata, prev_c); end
                total++; if (rid !== 1'b0) begin bad++; $display("FAIL single_res_id got=%0b want=0", rid); end
            end
            prev_c = c;
        end
        total++; if (lat_seen != LAT + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", lat_seen, LAT + 1); end
    endtask

    task automatic test_alternate();
        int ngr, prev_at;
        bit prev_g, g;
        ngr = 0; prev_at = 0; prev_g = 0;
        for (int k = 0; k < 42; k++) begin
            tick(1, 40'($urandom), 1, 40'($urandom), 24'($urandom), 1);
            total++; if (r0 !== exp_r0 || r1 !== exp_r1) begin bad++; $display("FAIL alt_ready k=%0d got=%0b%0b want=%0b%0b", k, r0, r1, exp_r0, exp_r1); end
            if (rv === 1'b1) begin
                total++; if (rid !== exp_id) begin bad++; $display("FAIL alt_res_id k=%0d got=%0b want=%0b", k, rid, exp_id); end
            end
            if (r0 === 1'b1 || r1 === 1'b1) begin
                g = r1;
                if (ngr > 0) begin
                    total++; if (g === prev_g) begin bad++; $display("FAIL alt_grant_order k=%0d got=%0b want=%0b", k, g, !prev_g); end
                    total++; if (k - prev_at != LAT + 2) begin bad++; $display("FAIL alt_spacing k=%0d got=%0d want=%0d", k, k - prev_at, LAT + 2); end
                end
                prev_g = g; prev_at = k; ngr++;
            end
        end
        total++; if (ngr < 8) begin bad++; $display("FAIL alt_grant_count got=%0d want>=8", ngr); end
        tick(0, 40'h0, 0, 40'h0, 24'h0, 1);
        tick(0, 40'h0, 0, 40'h0, 24'h0, 1);
        tick(0, 40'h0, 0, 40'h0, 24'h0, 1);
        tick(0, 40'h0, 0, 40'h0, 24'h0, 1);
        tick(0, 40'h0, 0, 40'h0, 24'h0, 1);
    endtask

    task automatic test_hold();
        bit seen;
        logic [23:0] hd;
        logic [7:0]  hc;
        seen = 0;
        tick(0, 40'h0, 1, 40'h00A5A5A5A5, 24'($urandom), 0);
        total++; if (r1 !== 1'b1) begin bad++; $display("FAIL hold_ready1 got=%0b want=1", r1); end
        for (int k = 0; k < 10 && !seen; k++) begin
            tick(0, 40'h0, 0, 40'h0, 24'($urandom), 0);
            if (rv === 1'b1) seen = 1;
        end
        total++; if (!seen) begin bad++; $display("FAIL hold_res_valid_timeout got=0 want=1"); end
        total++; if (rdata !== exp_data) begin bad++; $display("FAIL hold_capture got=%h want=%h", rdata, exp_data); end
        hd = exp_data; hc = exp_cnt;
        for (int k = 0; k < 10; k++) begin
            tick(1, 40'($urandom), 1, 40'($urandom), 24'($urandom), 0);
            total++; if (rv !== 1'b1) begin bad++; $display("FAIL hold_res_valid k=%0d got=%0b want=1", k, rv); end
            total++; if (rdata !== hd) begin bad++; $display("FAIL hold_res_data k=%0d got=%h want=%h", k, rdata, hd); end
            total++; if (rid !== 1'b1) begin bad++; $display("FAIL hold_res_id k=%0d got=%0b want=1", k, rid); end
            total++; if (r0 !== 1'b0 || r1 !== 1'b0) begin bad++; $display("FAIL hold_ready k=%0d got=%0b%0b want=00", k, r0, r1); end
            total++; if (jc !== hc) begin bad++; $display("FAIL hold_job_cnt k=%0d got=%0d want=%0d", k, jc, hc); end
        end
        tick(0, 40'h0, 0, 40'h0, 24'h0, 1);
        tick(0, 40'h0, 0, 40'h0, 24'h0, 0);
        total++; if (jc !== hc + 8'd1) begin bad++; $display("FAIL hold_release_cnt got=%0d want=%0d", jc, hc + 8'd1); end
        total++; if (bz !== 1'b0) begin bad++; $display("FAIL hold_release_busy got=%0b want=0", bz); end
    endtask

    task automatic test_rst_run();
        tick(1, 40'h5A5A5A5A5A, 0, 40'h0, 24'h0, 1);
        tick(0, 40'h0, 0, 40'h0, 24'($urandom), 1);
        tick(0, 40'h0, 0, 40'h0, 24'($urandom), 1);
        rst = 1;
        #1;
        total++; if (bz !== 1'b0) begin bad++; $display("FAIL rstrun_busy got=%0b want=0", bz); end
        total++; if (cseed !== 40'h0) begin bad++; $display("FAIL rstrun_core_seed got=%h want=0", cseed); end
        total++; if (rv !== 1'b0) begin bad++; $display("FAIL rstrun_res_valid got=%0b want=0", rv); end
        total++; if (rdata !== 24'h0) begin bad++; $display("FAIL rstrun_res_data got=%h want=0", rdata); end
        total++; if (jc !== 8'h0) begin bad++; $display("FAIL rstrun_job_cnt got=%0d want=0", jc); end
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            tick(0, 40'h0, 0, 40'h0, 24'($urandom), 1);
            total++; if (rv !== 1'b0 || bz !== 1'b0) begin bad++; $display("FAIL rstrun_after k=%0d got=%0b%0b want=00", k, rv, bz); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            tick($urandom_range(0, 2) != 0, 40'({$urandom, $urandom}),
                 $urandom_range(0, 2) != 0, 40'({$urandom, $urandom}),
                 24'($urandom), $urandom_range(0, 3) != 0);
            total++; if (r0 !== exp_r0) begin bad++; $display("FAIL rnd_ready0 i=%0d got=%0b want=%0b", i, r0, exp_r0); end
            total++; if (r1 !== exp_r1) begin bad++; $display("FAIL rnd_ready1 i=%0d got=%0b want=%0b", i, r1, exp_r1); end
            total++; if (bz !== exp_busy()) begin bad++; $display("FAIL rnd_busy i=%0d got=%0b want=%0b", i, bz, exp_busy()); end
            total++; if (rv !== exp_rv()) begin bad++; $display("FAIL rnd_res_valid i=%0d got=%0b want=%0b", i, rv, exp_rv()); end
            total++; if (cseed !== exp_seed) begin bad++; $display("FAIL rnd_core_seed i=%0d got=%h want=%h", i, cseed, exp_seed); end
            total++; if (rdata !== exp_data) begin bad++; $display("FAIL rnd_res_data i=%0d got=%h want=%h", i, rdata, exp_data); end
            total++; if (rid !== exp_id) begin bad++; $display("FAIL rnd_res_id i=%0d got=%0b want=%0b", i, rid, exp_id); end
            total++; if (jc !== exp_cnt) begin bad++; $display("FAIL rnd_job_cnt i=%0d got=%0d want=%0d", i, jc, exp_cnt); end
            if (i == 250) begin
                rst = 1;
                #1;
                total++; if (rv !== 1'b0 || bz !== 1'b0 || jc !== 8'h0) begin bad++; $display("FAIL rnd_async_reset got=%0b%0b/%0d want=00/0", rv, bz, jc); end
                apply_reset();
            end
        end
    endtask

    task automatic test_wrap();
        bit hit0, hit1;
        hit0 = 0; hit1 = 0;
        rst = 1;
        #1;
        apply_reset();
        for (int k = 0; k < 1500 && !hit1; k++) begin
            tick(1, 40'($urandom), $urandom_range(0, 1) != 0, 40'($urandom), 24'($urandom), 1);
            total++; if (jc !== exp_cnt) begin bad++; $display("FAIL wrap_cnt k=%0d got=%0d want=%0d", k, jc, exp_cnt); end
            if (ncomp == 256 && !hit0) begin
                hit0 = 1;
                total++; if (jc !== 8'h00) begin bad++; $display("FAIL wrap_256 got=%0d want=0", jc); end
            end
            if (ncomp == 257) begin
                hit1 = 1;
                total++; if (jc !== 8'h01) begin bad++; $display("FAIL wrap_257 got=%0d want=1", jc); end
            end
        end
        total++; if (!hit1) begin bad++; $display("FAIL wrap_timeout got=%0d want=257", ncomp); end
    endtask

    task automatic test_lat1();
        logic [23:0] c;
        c = 24'($urandom);
        @(posedge clk); #1;
        b_v1 = 1; b_s1 = 40'hFFFFFFFFFF; b_rr = 1; #1;
        total++; if (b_r1 !== 1'b1 || b_r0 !== 1'b0) begin bad++; $display("FAIL lat1_ready got=%0b%0b want=01", b_r0, b_r1); end
        @(posedge clk); #1;
        b_v1 = 0; b_cout = c; #1;
        total++; if (b_bz !== 1'b1 || b_rv !== 1'b0) begin bad++; $display("FAIL lat1_run got=%0b%0b want=10", b_bz, b_rv); end
        total++; if (b_cs !== 40'hFFFFFFFFFF) begin bad++; $display("FAIL lat1_core_seed got=%h want=ffffffffff", b_cs); end
        @(posedge clk); #1;
        b_cout = ~c; #1;
        total++; if (b_rv !== 1'b1) begin bad++; $display("FAIL lat1_res_valid got=%0b want=1", b_rv); end
        total++; if (b_rid !== 1'b1) begin bad++; $display("FAIL lat1_res_id got=%0b want=1", b_rid); end
        total++; if (b_rd !== c) begin bad++; $display("FAIL lat1_res_data got=%h want=%h", b_rd, c); end
        @(posedge clk); #2;
        total++; if (b_bz !== 1'b0 || b_jc !== 8'd1) begin bad++; $display("FAIL lat1_done got=%0b/%0d want=0/1", b_bz, b_jc); end
        b_s1 = 40'h0000000123; b_v1 = 1; #2; b_v1 = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #2;
            total++; if (b_bz !== 1'b0 || b_rv !== 1'b0) begin bad++; $display("FAIL lat1_drop k=%0d got=%0b%0b want=00", k, b_bz, b_rv); end
        end
        total++; if (b_cs !== 40'hFFFFFFFFFF) begin bad++; $display("FAIL lat1_drop_seed got=%h want=ffffffffff", b_cs); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_alternate();
        test_hold();
        test_rst_run();
        test_random();
        test_wrap();
        test_lat1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
